// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard time-edit path: scan codes, FSM
// state encoding and field indices.
package kbd_pkg;

    // PS/2 set-2 make codes that the edit controller reacts to
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_NEXT  = 8'h7A;
    localparam logic [7:0] KEY_PREV  = 8'h69;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    // Prefix bytes stripped before decode
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Field pointer values
    localparam logic [1:0] FLD_H = 2'd0;
    localparam logic [1:0] FLD_M = 2'd1;
    localparam logic [1:0] FLD_S = 2'd2;

endpackage

// File: rtl/ps2_prefix_filter.sv
// Strips E0 (extended) and F0 (break) prefixes from the PS/2 byte stream
// and emits one registered key event per make code.
module ps2_prefix_filter
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       got_data,
    output logic       key_valid,
    output logic [7:0] key_code
);

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;

    // Classify the incoming byte and decide the next flag/key values
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (got_data) begin
            if (scan_code == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (scan_code == PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Extended flag does not alter the decode; it only spans the sequence.
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                key_valid_d = ~brk_q;
                key_code_d  = scan_code;
            end
        end
    end

    // Flag and key-event registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/kbd_time_edit_ctrl.sv
// Keyboard-driven time edit controller: IDLE/EDIT/WRITE FSM, field pointer,
// per-field values with wrap-around and a req/ack write to the RTC writer.
module kbd_time_edit_ctrl
    import kbd_pkg::*;
#(
    parameter int FW    = 6,
    parameter int H_MAX = 23,
    parameter int M_MAX = 59,
    parameter int S_MAX = 59
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    scan_code,
    input  logic          got_data,
    input  logic [FW-1:0] cur_h,
    input  logic [FW-1:0] cur_m,
    input  logic [FW-1:0] cur_s,
    input  logic          wr_ack,
    output logic          edit_mode,
    output logic [1:0]    field_sel,
    output logic [FW-1:0] edit_h,
    output logic [FW-1:0] edit_m,
    output logic [FW-1:0] edit_s,
    output logic          wr_req
);

    localparam logic [FW-1:0] H_LIM = FW'(H_MAX);
    localparam logic [FW-1:0] M_LIM = FW'(M_MAX);
    localparam logic [FW-1:0] S_LIM = FW'(S_MAX);

    state_t        state_q, state_d;
    logic [1:0]    field_sel_q, field_sel_d;
    logic [FW-1:0] edit_h_q, edit_h_d;
    logic [FW-1:0] edit_m_q, edit_m_d;
    logic [FW-1:0] edit_s_q, edit_s_d;

    logic          key_valid;
    logic [7:0]    key_code;

    logic [FW-1:0] sel_val;
    logic [FW-1:0] sel_lim;
    logic [FW-1:0] inc_val;
    logic [FW-1:0] dec_val;
    logic [FW-1:0] new_val;
    logic          val_wr;

    ps2_prefix_filter u_filter (
        .clk       (clk),
        .rst       (rst),
        .scan_code (scan_code),
        .got_data  (got_data),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // Selected field value and its limit, plus wrapped inc/dec results
    always_comb begin
        sel_val = edit_h_q;
        sel_lim = H_LIM;
        case (field_sel_q)
            FLD_M:   begin sel_val = edit_m_q; sel_lim = M_LIM; end
            FLD_S:   begin sel_val = edit_s_q; sel_lim = S_LIM; end
            default: begin sel_val = edit_h_q; sel_lim = H_LIM; end
        endcase
        // Anything at or above the limit (including a corrupt snapshot) wraps to 0.
        inc_val = (sel_val >= sel_lim) ? '0 : sel_val + FW'(1);
        dec_val = (sel_val == '0) ? sel_lim : sel_val - FW'(1);
    end

    // Next-state and datapath decode for the edit FSM
    always_comb begin
        state_d     = state_q;
        field_sel_d = field_sel_q;
        edit_h_d    = edit_h_q;
        edit_m_d    = edit_m_q;
        edit_s_d    = edit_s_q;
        new_val     = sel_val;
        val_wr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && key_code == KEY_ENTER) begin
                    edit_h_d    = cur_h;
                    edit_m_d    = cur_m;
                    edit_s_d    = cur_s;
                    field_sel_d = FLD_H;
                    state_d     = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (key_valid) begin
                    case (key_code)
                        KEY_NEXT:  field_sel_d = (field_sel_q == FLD_S) ? FLD_H : field_sel_q + 2'd1;
                        KEY_PREV:  field_sel_d = (field_sel_q == FLD_H) ? FLD_S : field_sel_q - 2'd1;
                        KEY_UP:    begin new_val = inc_val; val_wr = 1'b1; end
                        KEY_DOWN:  begin new_val = dec_val; val_wr = 1'b1; end
                        KEY_ESC:   state_d = ST_IDLE;
                        KEY_ENTER: state_d = ST_WRITE;
                        default:   ;
                    endcase
                end
                if (val_wr) begin
                    case (field_sel_q)
                        FLD_M:   edit_m_d = new_val;
                        FLD_S:   edit_s_d = new_val;
                        default: edit_h_d = new_val;
                    endcase
                end
            end
            ST_WRITE: begin
                // Values are frozen here; only the acknowledge moves the FSM.
                if (wr_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and field registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            field_sel_q <= FLD_H;
            edit_h_q    <= '0;
            edit_m_q    <= '0;
            edit_s_q    <= '0;
        end else begin
            state_q     <= state_d;
            field_sel_q <= field_sel_d;
            edit_h_q    <= edit_h_d;
            edit_m_q    <= edit_m_d;
            edit_s_q    <= edit_s_d;
        end
    end

    assign edit_mode = (state_q != ST_IDLE);
    assign wr_req    = (state_q == ST_WRITE);
    assign field_sel = field_sel_q;
    assign edit_h    = edit_h_q;
    assign edit_m    = edit_m_q;
    assign edit_s    = edit_s_q;

endmodule

// File: tb/tb_kbd_time_edit_ctrl.sv
// Self-checking bench for kbd_time_edit_ctrl: a behavioural model tracks the
// expected outputs every cycle, and directed steps pin hand-computed values.
module tb_kbd_time_edit_ctrl;

    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    scan_code = 8'h00;
    logic          got_data = 1'b0;
    logic [FW-1:0] cur_h = '0, cur_m = '0, cur_s = '0;
    logic          wr_ack = 1'b0;
    logic          edit_mode;
    logic [1:0]    field_sel;
    logic [FW-1:0] edit_h, edit_m, edit_s;
    logic          wr_req;

    int n_cmp = 0;
    int n_err = 0;
    bit req_seen = 0;

    kbd_time_edit_ctrl #(.FW(FW), .H_MAX(23), .M_MAX(59), .S_MAX(59)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_code (scan_code),
        .got_data  (got_data),
        .cur_h     (cur_h),
        .cur_m     (cur_m),
        .cur_s     (cur_s),
        .wr_ack    (wr_ack),
        .edit_mode (edit_mode),
        .field_sel (field_sel),
        .edit_h    (edit_h),
        .edit_m    (edit_m),
        .edit_s    (edit_s),
        .wr_req    (wr_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode is tracked as two booleans; fields as an array indexed by pointer.
    bit m_editing = 0;
    bit m_writing = 0;
    int m_ptr = 0;
    int m_fld[3] = '{0, 0, 0};
    int m_lim[3] = '{23, 59, 59};
    bit m_brk = 0;
    bit m_pend = 0;
    int m_key = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_editing = 0; m_writing = 0; m_ptr = 0;
            m_fld = '{0, 0, 0};
            m_brk = 0; m_pend = 0;
        end else begin
            if (m_writing) begin
                if (wr_ack) begin m_writing = 0; m_editing = 0; end
            end else if (m_pend) begin
                if (!m_editing) begin
                    if (m_key == 'h5A) begin
                        m_fld = '{int'(cur_h), int'(cur_m), int'(cur_s)};
                        m_ptr = 0; m_editing = 1;
                    end
                end else begin
                    case (m_key)
                        'h7A: m_ptr = (m_ptr + 1) % 3;
                        'h69: m_ptr = (m_ptr + 2) % 3;
                        'h75: m_fld[m_ptr] = (m_fld[m_ptr] >= m_lim[m_ptr]) ? 0 : m_fld[m_ptr] + 1;
                        'h72: m_fld[m_ptr] = (m_fld[m_ptr] == 0) ? m_lim[m_ptr] : m_fld[m_ptr] - 1;
                        'h76: m_editing = 0;
                        'h5A: m_writing = 1;
                        default: ;
                    endcase
                end
            end
            m_pend = 0;
            if (got_data) begin
                if (scan_code == 8'hF0) m_brk = 1;
                else if (scan_code != 8'hE0) begin
                    if (!m_brk) begin m_pend = 1; m_key = int'(scan_code); end
                    m_brk = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_req) req_seen = 1;
            check("edit_mode", int'(edit_mode), int'(m_editing || m_writing));
            check("field_sel", int'(field_sel), m_ptr);
            check("edit_h", int'(edit_h), m_fld[0]);
            check("edit_m", int'(edit_m), m_fld[1]);
            check("edit_s", int'(edit_s), m_fld[2]);
            check("wr_req", int'(wr_req), int'(m_writing));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        got_data  = 1'b1;
        @(negedge clk);
        got_data  = 1'b0;
    endtask

    // Byte in, then allow the key event and the state update to land
    task automatic send_key(input logic [7:0] b);
        send_byte(b);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_h = FW'(h); cur_m = FW'(m); cur_s = FW'(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset edit_mode", int'(edit_mode), 0);
        check("reset wr_req", int'(wr_req), 0);
        check("reset field_sel", int'(field_sel), 0);

        // Snapshot on Enter
        set_cur(12, 34, 56);
        send_key(8'h5A);
        check("enter edit_mode", int'(edit_mode), 1);
        check("enter edit_h", int'(edit_h), 12);
        check("enter edit_m", int'(edit_m), 34);
        check("enter edit_s", int'(edit_s), 56);

        // Esc leaves values intact
        send_key(8'h76);
        check("esc edit_mode", int'(edit_mode), 0);
        check("esc keeps edit_s", int'(edit_s), 56);

        // Wrap at hour/minute limits
        set_cur(23, 59, 0);
        send_key(8'h5A);
        send_key(8'h75);
        check("h 23 up", int'(edit_h), 0);
        send_key(8'h72);
        check("h 0 down", int'(edit_h), 23);
        send_key(8'h7A);
        send_key(8'h75);
        check("m 59 up", int'(edit_m), 0);
        send_key(8'h72);
        check("m 0 down", int'(edit_m), 59);

        // Pointer wrap and extended prefix
        send_key(8'h69);
        check("prev 1->0", int'(field_sel), 0);
        send_key(8'h69);
        check("prev 0->2", int'(field_sel), 2);
        send_key(8'h7A);
        check("next 2->0", int'(field_sel), 0);
        send_byte(8'hE0);
        send_key(8'h7A);
        check("E0 7A ->1", int'(field_sel), 1);

        // Break sequences produce nothing; the next plain make works
        send_byte(8'hF0);
        send_key(8'h75);
        check("F0 75 no change", int'(edit_m), 59);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_key(8'h75);
        check("E0 F0 75 no change", int'(edit_m), 59);
        send_key(8'h75);
        check("75 after break", int'(edit_m), 0);

        // Commit: request held, keys ignored, ack releases
        send_key(8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wr_req held", int'(wr_req), 1);
            check("wr data h", int'(edit_h), 23);
        end
        send_key(8'h5A);
        send_key(8'h75);
        check("write ignores keys m", int'(edit_m), 0);
        check("write still req", int'(wr_req), 1);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("ack drops wr_req", int'(wr_req), 0);
        check("ack idle", int'(edit_mode), 0);

        // Ack in IDLE is ignored
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        @(negedge clk);

        // Corrupt snapshot wraps to 0 on increment
        set_cur(63, 10, 20);
        send_key(8'h5A);
        send_key(8'h75);
        check("corrupt h up", int'(edit_h), 0);
        send_key(8'h72);
        check("h down to limit", int'(edit_h), 23);

        // Reset in the middle of a write
        send_key(8'h5A);
        check("pre-reset wr_req", int'(wr_req), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst wr_req", int'(wr_req), 0);
        check("rst edit_mode", int'(edit_mode), 0);
        check("rst edit_h", int'(edit_h), 0);
        check("rst edit_s", int'(edit_s), 0);

        // Esc path never requests a write
        req_seen = 0;
        set_cur(1, 2, 3);
        send_key(8'h5A);
        send_key(8'h76);
        repeat (3) @(negedge clk);
        check("esc no wr_req", int'(req_seen), 0);
        check("esc idle", int'(edit_mode), 0);
        check("esc keeps m", int'(edit_m), 2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
